// File: rtl/tlu_trig_scheduler.sv
// Trigger scheduler: accepts coincidence/test requests, issues one trigger pulse
// with a fresh TRIG_ID when all enabled DUT channels are ready, waits for READY
// to return (with optional timeout), then holds off for a programmable dead time.
module tlu_trig_scheduler #(
   parameter int N_DUT = 6,
   parameter int ID_W  = 32
) (
   input  logic             SYS_CLK,
   input  logic             SYS_RST_N,
   input  logic             START,
   input  logic             STOP,
   input  logic             TRIG_REQ,
   input  logic             TEST_TRIG,
   input  logic [N_DUT-1:0] CONF_EN_OUTPUT,
   input  logic [15:0]      CONF_TIME_OUT,
   input  logic [15:0]      CONF_DEADTIME,
   input  logic [ID_W-1:0]  CONF_MAX_TRIG,
   input  logic [N_DUT-1:0] DUT_READY,
   input  logic             RECORD_FULL,
   output logic             TRIG_OUT,
   output logic [ID_W-1:0]  TRIG_ID,
   output logic             RECORD_WR,
   output logic             RUNNING,
   output logic             BUSY,
   output logic [ID_W-1:0]  SKIP_CNT,
   output logic [7:0]       TIMEOUT_CNT,
   output logic [7:0]       LOST_CNT
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_RDY = 2'd1,
      DEAD     = 2'd2,
      DONE     = 2'd3
   } state_t;

   localparam logic [ID_W-1:0] ID_ONE = {{(ID_W-1){1'b0}}, 1'b1};

   state_t      state;
   state_t      state_nxt;
   logic [15:0] to_cnt;
   logic [15:0] dead_cnt;
   logic        req;
   logic        allrdy;
   logic        limit_hit;
   logic        accept;
   logic        skip;
   logic        to_hit;

   assign req    = TRIG_REQ | TEST_TRIG;
   assign allrdy = ((DUT_READY & CONF_EN_OUTPUT) == CONF_EN_OUTPUT);
   // TRIG_ID advances once per issued trigger and clears on START, so it doubles
   // as the issued-trigger count for the limit comparison.
   assign limit_hit = (CONF_MAX_TRIG != '0) && (TRIG_ID == CONF_MAX_TRIG);
   assign BUSY      = (state != IDLE);

   // State register
   always_ff @(posedge SYS_CLK) begin
      if (!SYS_RST_N) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic and per-cycle event strobes
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      skip      = 1'b0;
      to_hit    = 1'b0;
      case (state)
         IDLE: begin
            if (RUNNING && req && allrdy) begin
               accept    = 1'b1;
               state_nxt = WAIT_RDY;
            end
         end
         WAIT_RDY: begin
            // to_cnt == 0 marks the guard cycle where READY is still stale
            if (to_cnt != 16'd0) begin
               if (allrdy) begin
                  state_nxt = DEAD;
               end else if ((CONF_TIME_OUT != 16'd0) && (to_cnt == CONF_TIME_OUT)) begin
                  to_hit    = 1'b1;
                  state_nxt = DEAD;
               end
            end
         end
         DEAD: begin
            if (dead_cnt == 16'd0) begin
               // a stopped run finishes its sequence back in IDLE
               state_nxt = (limit_hit && RUNNING) ? DONE : IDLE;
            end
         end
         DONE: begin
            state_nxt = DONE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
      skip = RUNNING && req && !accept;
      if (START) begin
         state_nxt = IDLE;
         accept    = 1'b0;
         skip      = 1'b0;
         to_hit    = 1'b0;
      end
   end

   // Sequence timers: READY timeout counter and dead-time countdown
   always_ff @(posedge SYS_CLK) begin
      if (!SYS_RST_N) begin
         to_cnt   <= 16'd0;
         dead_cnt <= 16'd0;
      end else begin
         if (state_nxt == WAIT_RDY && state != WAIT_RDY) begin
            to_cnt <= 16'd0;
         end else if (state == WAIT_RDY && to_cnt != 16'hffff) begin
            to_cnt <= to_cnt + 16'd1;
         end
         if (state_nxt == DEAD && state != DEAD) begin
            dead_cnt <= CONF_DEADTIME;
         end else if (state == DEAD && dead_cnt != 16'd0) begin
            dead_cnt <= dead_cnt - 16'd1;
         end
      end
   end

   // Trigger outputs, run flag, trigger ID and event counters
   always_ff @(posedge SYS_CLK) begin
      if (!SYS_RST_N) begin
         TRIG_OUT    <= 1'b0;
         RECORD_WR   <= 1'b0;
         RUNNING     <= 1'b0;
         TRIG_ID     <= '0;
         SKIP_CNT    <= '0;
         TIMEOUT_CNT <= 8'd0;
         LOST_CNT    <= 8'd0;
      end else begin
         TRIG_OUT  <= accept;
         RECORD_WR <= accept;
         if (START) begin
            RUNNING     <= !STOP;
            TRIG_ID     <= '0;
            SKIP_CNT    <= '0;
            TIMEOUT_CNT <= 8'd0;
            LOST_CNT    <= 8'd0;
         end else begin
            if (STOP || (state == DEAD && state_nxt == DONE)) begin
               RUNNING <= 1'b0;
            end
            if (TRIG_OUT) begin
               TRIG_ID <= TRIG_ID + ID_ONE;
            end
            if (skip) begin
               SKIP_CNT <= SKIP_CNT + ID_ONE;
            end
            if (to_hit && TIMEOUT_CNT != 8'hff) begin
               TIMEOUT_CNT <= TIMEOUT_CNT + 8'd1;
            end
            if (RECORD_WR && RECORD_FULL && LOST_CNT != 8'hff) begin
               LOST_CNT <= LOST_CNT + 8'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_tlu_trig_scheduler.sv
// Directed bench for tlu_trig_scheduler: a cycle-by-cycle vector table for the
// basic handshake plus hand-written sequences for timeout, dead time, limit,
// lost-record counting and mid-sequence reset.
module tb_tlu_trig_scheduler;

   logic        SYS_CLK = 1'b0;
   logic        SYS_RST_N;
   logic        START, STOP, TRIG_REQ, TEST_TRIG;
   logic [5:0]  CONF_EN_OUTPUT;
   logic [15:0] CONF_TIME_OUT, CONF_DEADTIME;
   logic [31:0] CONF_MAX_TRIG;
   logic [5:0]  DUT_READY;
   logic        RECORD_FULL;
   logic        TRIG_OUT;
   logic [31:0] TRIG_ID;
   logic        RECORD_WR, RUNNING, BUSY;
   logic [31:0] SKIP_CNT;
   logic [7:0]  TIMEOUT_CNT, LOST_CNT;

   int errors = 0;
   int checks = 0;

   tlu_trig_scheduler #(.N_DUT(6), .ID_W(32)) dut (
      .SYS_CLK(SYS_CLK), .SYS_RST_N(SYS_RST_N), .START(START), .STOP(STOP),
      .TRIG_REQ(TRIG_REQ), .TEST_TRIG(TEST_TRIG), .CONF_EN_OUTPUT(CONF_EN_OUTPUT),
      .CONF_TIME_OUT(CONF_TIME_OUT), .CONF_DEADTIME(CONF_DEADTIME),
      .CONF_MAX_TRIG(CONF_MAX_TRIG), .DUT_READY(DUT_READY), .RECORD_FULL(RECORD_FULL),
      .TRIG_OUT(TRIG_OUT), .TRIG_ID(TRIG_ID), .RECORD_WR(RECORD_WR), .RUNNING(RUNNING),
      .BUSY(BUSY), .SKIP_CNT(SKIP_CNT), .TIMEOUT_CNT(TIMEOUT_CNT), .LOST_CNT(LOST_CNT)
   );

   always #5 SYS_CLK = ~SYS_CLK;

   typedef struct {
      logic        start, stop, req, test;
      logic [5:0]  rdy;
      logic        e_trig;
      logic [31:0] e_id;
      logic        e_busy, e_run;
      logic [31:0] e_skip;
   } vec_t;

   vec_t tv[17];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Inputs are driven and outputs sampled on the falling edge.
   task automatic cyc();
      @(negedge SYS_CLK);
   endtask

   task automatic pulse_start();
      START = 1'b1;
      cyc();
      START = 1'b0;
   endtask

   task automatic wait_idle(input int max_cyc, output int n);
      n = 0;
      while (BUSY === 1'b1 && n < max_cyc) begin
         cyc();
         n++;
      end
      chk("wait_idle_bound", {63'd0, BUSY}, 64'd0);
   endtask

   initial begin
      int n, trigs, last, gap_err, busy_cyc;

      // Vectors: inputs during one cycle, expected outputs after its clock edge
      tv[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 6'h3f, 1'b0, 32'd0, 1'b0, 1'b1, 32'd0};
      tv[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 6'h3f, 1'b1, 32'd0, 1'b1, 1'b1, 32'd0};
      tv[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 6'h3f, 1'b0, 32'd1, 1'b1, 1'b1, 32'd1};
      tv[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 6'h3f, 1'b0, 32'd1, 1'b1, 1'b1, 32'd1};
      tv[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 6'h3f, 1'b0, 32'd1, 1'b0, 1'b1, 32'd2};
      tv[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 6'h3f, 1'b1, 32'd1, 1'b1, 1'b1, 32'd2};
      tv[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 1'b0, 32'd2, 1'b1, 1'b1, 32'd2};
      tv[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 6'h00, 1'b0, 32'd2, 1'b1, 1'b1, 32'd3};
      tv[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 6'h3f, 1'b0, 32'd2, 1'b1, 1'b1, 32'd3};
      tv[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 6'h3f, 1'b0, 32'd2, 1'b0, 1'b1, 32'd3};
      tv[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 6'h3f, 1'b0, 32'd2, 1'b0, 1'b0, 32'd3};
      tv[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 6'h3f, 1'b0, 32'd2, 1'b0, 1'b0, 32'd3};
      tv[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 6'h3f, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0};
      tv[13] = '{1'b1, 1'b0, 1'b1, 1'b0, 6'h3f, 1'b0, 32'd0, 1'b0, 1'b1, 32'd0};
      tv[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 6'h3e, 1'b0, 32'd0, 1'b0, 1'b1, 32'd1};
      tv[15] = '{1'b0, 1'b0, 1'b1, 1'b0, 6'h3f, 1'b1, 32'd0, 1'b1, 1'b1, 32'd1};
      tv[16] = '{1'b1, 1'b0, 1'b0, 1'b0, 6'h3f, 1'b0, 32'd0, 1'b0, 1'b1, 32'd0};

      SYS_RST_N = 1'b0; START = 1'b0; STOP = 1'b0; TRIG_REQ = 1'b0; TEST_TRIG = 1'b0;
      CONF_EN_OUTPUT = 6'h3f; CONF_TIME_OUT = 16'd100; CONF_DEADTIME = 16'd0;
      CONF_MAX_TRIG = 32'd0; DUT_READY = 6'h3f; RECORD_FULL = 1'b0;

      // Reset state
      cyc(); cyc();
      chk("rst_trig", {63'd0, TRIG_OUT}, 64'd0);
      chk("rst_id", {32'd0, TRIG_ID}, 64'd0);
      chk("rst_wr", {63'd0, RECORD_WR}, 64'd0);
      chk("rst_run", {63'd0, RUNNING}, 64'd0);
      chk("rst_busy", {63'd0, BUSY}, 64'd0);
      chk("rst_skip", {32'd0, SKIP_CNT}, 64'd0);
      chk("rst_to", {56'd0, TIMEOUT_CNT}, 64'd0);
      chk("rst_lost", {56'd0, LOST_CNT}, 64'd0);
      SYS_RST_N = 1'b1;
      cyc();

      // Basic handshake table
      for (int i = 0; i < 17; i++) begin
         START = tv[i].start; STOP = tv[i].stop; TRIG_REQ = tv[i].req;
         TEST_TRIG = tv[i].test; DUT_READY = tv[i].rdy;
         cyc();
         chk($sformatf("v%0d_trig", i), {63'd0, TRIG_OUT}, {63'd0, tv[i].e_trig});
         chk($sformatf("v%0d_wr", i), {63'd0, RECORD_WR}, {63'd0, tv[i].e_trig});
         chk($sformatf("v%0d_id", i), {32'd0, TRIG_ID}, {32'd0, tv[i].e_id});
         chk($sformatf("v%0d_busy", i), {63'd0, BUSY}, {63'd0, tv[i].e_busy});
         chk($sformatf("v%0d_run", i), {63'd0, RUNNING}, {63'd0, tv[i].e_run});
         chk($sformatf("v%0d_skip", i), {32'd0, SKIP_CNT}, {32'd0, tv[i].e_skip});
      end
      START = 1'b0; STOP = 1'b0; TRIG_REQ = 1'b0; TEST_TRIG = 1'b0; DUT_READY = 6'h3f;

      // READY[2] low for 10 cycles from the trigger cycle, dead time 5
      CONF_DEADTIME = 16'd5; CONF_TIME_OUT = 16'd100;
      pulse_start();
      TRIG_REQ = 1'b1;
      cyc();
      TRIG_REQ = 1'b0;
      chk("t2_trig", {63'd0, TRIG_OUT}, 64'd1);
      DUT_READY = 6'h3b;
      busy_cyc = 0;
      while (BUSY === 1'b1 && busy_cyc < 200) begin
         busy_cyc++;
         if (busy_cyc == 11) DUT_READY = 6'h3f;
         cyc();
      end
      chk("t2_busy_cycles", busy_cyc, 17);
      chk("t2_timeouts", {56'd0, TIMEOUT_CNT}, 64'd0);
      chk("t2_id", {32'd0, TRIG_ID}, 64'd1);

      // READY[0] stuck low, timeout 20
      CONF_DEADTIME = 16'd0; CONF_TIME_OUT = 16'd20; DUT_READY = 6'h3e;
      pulse_start();
      DUT_READY = 6'h3f;
      TRIG_REQ = 1'b1;
      cyc();
      TRIG_REQ = 1'b0;
      DUT_READY = 6'h3e;
      wait_idle(200, n);
      chk("t3_busy_cycles", n, 22);
      chk("t3_timeouts", {56'd0, TIMEOUT_CNT}, 64'd1);
      TRIG_REQ = 1'b1;
      cyc();
      TRIG_REQ = 1'b0;
      chk("t3_no_trig", {63'd0, TRIG_OUT}, 64'd0);
      chk("t3_skip", {32'd0, SKIP_CNT}, 64'd1);
      DUT_READY = 6'h3f;

      // REQ held 50 cycles, dead time 3: one trigger every 7 cycles
      CONF_DEADTIME = 16'd3; CONF_TIME_OUT = 16'd100;
      pulse_start();
      TRIG_REQ = 1'b1;
      trigs = 0; last = -1; gap_err = 0;
      for (int k = 0; k < 50; k++) begin
         cyc();
         if (TRIG_OUT === 1'b1) begin
            if (last >= 0 && (k - last) != 7) gap_err++;
            last = k;
            trigs++;
         end
      end
      TRIG_REQ = 1'b0;
      chk("t4_trigs", trigs, 8);
      chk("t4_gap_err", gap_err, 0);
      chk("t4_skip", {32'd0, SKIP_CNT}, 64'd42);
      wait_idle(50, n);

      // Trigger limit 3
      CONF_DEADTIME = 16'd0; CONF_MAX_TRIG = 32'd3;
      pulse_start();
      TRIG_REQ = 1'b1;
      trigs = 0;
      for (int k = 0; k < 60; k++) begin
         cyc();
         if (TRIG_OUT === 1'b1) trigs++;
      end
      TRIG_REQ = 1'b0;
      chk("t5_trigs", trigs, 3);
      chk("t5_id", {32'd0, TRIG_ID}, 64'd3);
      chk("t5_run", {63'd0, RUNNING}, 64'd0);
      chk("t5_done_busy", {63'd0, BUSY}, 64'd1);
      pulse_start();
      chk("t5_rearm_id", {32'd0, TRIG_ID}, 64'd0);
      chk("t5_rearm_run", {63'd0, RUNNING}, 64'd1);
      chk("t5_rearm_busy", {63'd0, BUSY}, 64'd0);
      CONF_MAX_TRIG = 32'd0;

      // Two triggers into a full record FIFO, then reset during DEAD
      RECORD_FULL = 1'b1;
      for (int k = 0; k < 2; k++) begin
         TRIG_REQ = 1'b1;
         cyc();
         TRIG_REQ = 1'b0;
         chk("t6_trig", {63'd0, TRIG_OUT}, 64'd1);
         wait_idle(50, n);
      end
      RECORD_FULL = 1'b0;
      chk("t6_lost", {56'd0, LOST_CNT}, 64'd2);
      CONF_DEADTIME = 16'd10;
      TRIG_REQ = 1'b1;
      cyc();
      TRIG_REQ = 1'b0;
      cyc(); cyc(); cyc();
      chk("t6_in_dead", {63'd0, BUSY}, 64'd1);
      SYS_RST_N = 1'b0;
      cyc();
      chk("t6_rst_trig", {63'd0, TRIG_OUT}, 64'd0);
      chk("t6_rst_id", {32'd0, TRIG_ID}, 64'd0);
      chk("t6_rst_busy", {63'd0, BUSY}, 64'd0);
      chk("t6_rst_run", {63'd0, RUNNING}, 64'd0);
      chk("t6_rst_lost", {56'd0, LOST_CNT}, 64'd0);
      SYS_RST_N = 1'b1;
      cyc();
      chk("t6_post_trig", {63'd0, TRIG_OUT}, 64'd0);
      chk("t6_post_busy", {63'd0, BUSY}, 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
